// File: rtl/conf_int_mac__pipe__apx_sel.sv
// Pipelined, precision-configurable unsigned integer MAC.
// Three valid/ready stages: S1 truncates the operands to the requested
// approximation level, S2 forms the exact product, S3 loads or accumulates it.
// Any stage may move forward whenever the stage after it is empty or is
// moving on, so the pipe sustains one transaction per cycle under full flow.
// Legal parameterisations keep MAX_LVL*TRUNC_STEP < DW and MAX_LVL < 2**LVL_W.
module conf_int_mac__pipe__apx_sel #(
    parameter int DATA_PATH_BITWIDTH = 24,
    parameter int TRUNC_STEP         = 8,
    parameter int MAX_LVL            = 2,
    parameter int LVL_W              = 2,
    parameter int ACC_GUARD          = 8,
    localparam int DW                = DATA_PATH_BITWIDTH,
    localparam int ACC_W             = 2*DW + ACC_GUARD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in__valid,
    output logic             in__ready,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    input  logic [LVL_W-1:0] apx__lvl,
    input  logic             acc__en,
    input  logic             acc__clr,
    output logic             out__valid,
    input  logic             out__ready,
    output logic [ACC_W-1:0] d,
    output logic [LVL_W-1:0] d__lvl,
    output logic             ovf
);

    localparam int STAGES = 3;

    // Per-stage valid bits; bit N belongs to stage SN.
    logic [STAGES:1] vld_pipe;

    logic             ld3;
    logic             en2;
    logic             en1;
    logic             in_xfer;

    logic [LVL_W-1:0] lvl_eff;
    logic [DW-1:0]    op_mask;

    logic [DW-1:0]    s1_a;
    logic [DW-1:0]    s1_b;
    logic [LVL_W-1:0] s1_lvl;
    logic             s1_en;
    logic             s1_clr;

    logic [2*DW-1:0]  s2_p;
    logic [LVL_W-1:0] s2_lvl;
    logic             s2_en;
    logic             s2_clr;

    logic [ACC_W-1:0] p_ext;
    logic [ACC_W:0]   acc_sum;

    // A stage takes new content when its successor is empty or is advancing.
    assign ld3        = !vld_pipe[3] | out__ready;
    assign en2        = ld3 | !vld_pipe[2];
    assign en1        = en2 | !vld_pipe[1];
    assign in__ready  = en1 & !rst;
    assign in_xfer    = in__valid & in__ready;
    assign out__valid = vld_pipe[3];

    // Clamp the requested level and build the operand LSB mask for it.
    always_comb begin
        lvl_eff = apx__lvl;
        if (apx__lvl > LVL_W'(MAX_LVL)) lvl_eff = LVL_W'(MAX_LVL);
        op_mask = {DW{1'b1}};
        for (int l = 1; l <= MAX_LVL; l++) begin
            if (lvl_eff == LVL_W'(l)) op_mask = {DW{1'b1}} << (l*TRUNC_STEP);
        end
    end

    // Valid bits move forward together with the stage they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            if (ld3) vld_pipe[3] <= vld_pipe[2];
            if (en2) vld_pipe[2] <= vld_pipe[1];
            if (en1) vld_pipe[1] <= in_xfer;
        end
    end

    // S1: capture truncated operands and per-transaction control.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_a   <= '0;
            s1_b   <= '0;
            s1_lvl <= '0;
            s1_en  <= 1'b0;
            s1_clr <= 1'b0;
        end else if (in_xfer) begin
            s1_a   <= a & op_mask;
            s1_b   <= b & op_mask;
            s1_lvl <= lvl_eff;
            s1_en  <= acc__en;
            s1_clr <= acc__clr;
        end
    end

    // S2: exact full-width product of the truncated operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_p   <= '0;
            s2_lvl <= '0;
            s2_en  <= 1'b0;
            s2_clr <= 1'b0;
        end else if (en2 && vld_pipe[1]) begin
            s2_p   <= (2*DW)'(s1_a) * (2*DW)'(s1_b);
            s2_lvl <= s1_lvl;
            s2_en  <= s1_en;
            s2_clr <= s1_clr;
        end
    end

    assign p_ext   = ACC_W'(s2_p);
    assign acc_sum = {1'b0, d} + {1'b0, p_ext};

    // S3: the output register doubles as the accumulator. It only changes
    // when a real product arrives, so idle cycles and stalls leave the sum
    // (and the held output) untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d      <= '0;
            d__lvl <= '0;
            ovf    <= 1'b0;
        end else if (ld3 && vld_pipe[2]) begin
            d__lvl <= s2_lvl;
            if (!s2_en || s2_clr) begin
                d   <= p_ext;
                ovf <= 1'b0;
            end else begin
                d   <= acc_sum[ACC_W-1:0];
                ovf <= ovf | acc_sum[ACC_W];
            end
        end
    end

endmodule
